// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers BCD digits from a scanned 4-digit seven-segment bus.
// Latency: STABLE_CYCLES+4 edges from input change to sample_strobe; frame_valid pulses with the 4th distinct digit capture.
// Backpressure: none; the bus is sampled continuously and every settled digit pattern is captured once.
//
// Ports:
//   clk, rst_n      - rising-edge clock, asynchronous active-low reset
//   anode[3:0]      - active-low digit selects (digit i active when anode[i]=0)
//   segment[6:0]    - active-high segment lines, bit0=a .. bit6=g
//   bcd_digits      - last complete frame, digit i in [4i+3:4i]
//   bad_pattern     - per-digit "not a 0-9 code" flags for the last frame
//   frame_valid     - one-cycle pulse when bcd_digits/bad_pattern update
//   sample_strobe   - one-cycle pulse per accepted digit capture
//   sample_digit    - captured digit index (valid with sample_strobe)
//   sample_bcd      - captured nibble, 4'hF for an unrecognised pattern
//   anode_err       - one-cycle pulse when a settled anode has several bits low
module sevenseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  output logic [15:0] bcd_digits,
  output logic [3:0]  bad_pattern,
  output logic        frame_valid,
  output logic        sample_strobe,
  output logic [1:0]  sample_digit,
  output logic [3:0]  sample_bcd,
  output logic        anode_err
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Blank bus: all anodes off, all segments off.
  localparam logic [10:0]      BLANK    = {4'hF, 7'h00};

  typedef enum logic {
    HOLD   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Returns {bad, nibble}; unknown codes give nibble F with bad set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = {1'b1, 4'hF};
    case (seg)
      7'h3F:   r = {1'b0, 4'd0};
      7'h06:   r = {1'b0, 4'd1};
      7'h5B:   r = {1'b0, 4'd2};
      7'h4F:   r = {1'b0, 4'd3};
      7'h66:   r = {1'b0, 4'd4};
      7'h6D:   r = {1'b0, 4'd5};
      7'h7D:   r = {1'b0, 4'd6};
      7'h07:   r = {1'b0, 4'd7};
      7'h7F:   r = {1'b0, 4'd8};
      7'h6F:   r = {1'b0, 4'd9};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Synchronizer (sync1 -> s) and one-cycle delayed copy of s.
  logic [10:0]       sync1_q;
  logic [10:0]       s_q;
  logic [10:0]       sd_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [3:0]        seen_q, seen_d;
  logic [3:0][3:0]   shadow_nib_q, shadow_nib_d;
  logic [3:0]        shadow_bad_q, shadow_bad_d;

  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        bad_q, bad_d;
  logic              fv_q, fv_d;
  logic              strobe_q, strobe_d;
  logic [1:0]        sdigit_q, sdigit_d;
  logic [3:0]        sbcd_q, sbcd_d;
  logic              aerr_q, aerr_d;

  logic              s_same;
  logic              capture_go;
  logic              hit;
  logic [1:0]        idx;
  logic [4:0]        dec;
  logic [3:0]        seen_nxt;

  assign s_same     = (s_q == sd_q);
  // Capture fires once per settle episode; HOLD ignores the saturated counter
  // so a steady bus never produces a second capture.
  assign capture_go = (state_q == SETTLE) && s_same && (cnt_q == STABLE_C);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seen_d       = seen_q;
    shadow_nib_d = shadow_nib_q;
    shadow_bad_d = shadow_bad_q;
    bcd_d        = bcd_q;
    bad_d        = bad_q;
    fv_d         = 1'b0;
    strobe_d     = 1'b0;
    sdigit_d     = sdigit_q;
    sbcd_d       = sbcd_q;
    aerr_d       = 1'b0;
    hit          = 1'b0;
    idx          = 2'd0;
    dec          = decode_seg(s_q[6:0]);
    seen_nxt     = seen_q;

    // Stability counter: saturating count of consecutive identical samples.
    if (s_same) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      HOLD: begin
        if (!s_same) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!s_same) begin
          state_d = SETTLE;
        end else if (cnt_q == STABLE_C) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase

    if (capture_go) begin
      case (s_q[10:7])
        4'b1110: begin hit = 1'b1; idx = 2'd0; end
        4'b1101: begin hit = 1'b1; idx = 2'd1; end
        4'b1011: begin hit = 1'b1; idx = 2'd2; end
        4'b0111: begin hit = 1'b1; idx = 2'd3; end
        4'b1111: hit = 1'b0;           // blank slot between digits
        default: aerr_d = 1'b1;        // two or more digits driven at once
      endcase
    end

    if (hit) begin
      strobe_d          = 1'b1;
      sdigit_d          = idx;
      sbcd_d            = dec[3:0];
      shadow_nib_d[idx] = dec[3:0];
      shadow_bad_d[idx] = dec[4];
      seen_nxt          = seen_q | (4'b0001 << idx);
      if (&seen_nxt) begin
        // Frame includes the capture being made on this edge.
        bcd_d  = shadow_nib_d;
        bad_d  = shadow_bad_d;
        fv_d   = 1'b1;
        seen_d = 4'b0000;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= BLANK;
      s_q          <= BLANK;
      sd_q         <= BLANK;
      cnt_q        <= '0;
      state_q      <= HOLD;
      seen_q       <= 4'b0000;
      shadow_nib_q <= '0;
      shadow_bad_q <= 4'b0000;
      bcd_q        <= 16'h0000;
      bad_q        <= 4'b0000;
      fv_q         <= 1'b0;
      strobe_q     <= 1'b0;
      sdigit_q     <= 2'd0;
      sbcd_q       <= 4'h0;
      aerr_q       <= 1'b0;
    end else begin
      sync1_q      <= {anode, segment};
      s_q          <= sync1_q;
      sd_q         <= s_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      seen_q       <= seen_d;
      shadow_nib_q <= shadow_nib_d;
      shadow_bad_q <= shadow_bad_d;
      bcd_q        <= bcd_d;
      bad_q        <= bad_d;
      fv_q         <= fv_d;
      strobe_q     <= strobe_d;
      sdigit_q     <= sdigit_d;
      sbcd_q       <= sbcd_d;
      aerr_q       <= aerr_d;
    end
  end

  assign bcd_digits    = bcd_q;
  assign bad_pattern   = bad_q;
  assign frame_valid   = fv_q;
  assign sample_strobe = strobe_q;
  assign sample_digit  = sdigit_q;
  assign sample_bcd    = sbcd_q;
  assign anode_err     = aerr_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic [15:0] bcd_digits;
  logic [3:0]  bad_pattern;
  logic        frame_valid;
  logic        sample_strobe;
  logic [1:0]  sample_digit;
  logic [3:0]  sample_bcd;
  logic        anode_err;

  int checks = 0;
  int errors = 0;

  // Event bookkeeping filled in by tick().
  int         strobe_cnt = 0;
  int         fv_cnt     = 0;
  int         err_cnt    = 0;
  int         fv_lone    = 0;   // frame_valid seen without a strobe in the same cycle
  logic [1:0] last_digit = 2'd0;
  logic [3:0] last_bcd   = 4'h0;
  logic [1:0] fv_digit   = 2'd0;

  sevenseg_scan_decoder #(
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .anode(anode),
    .segment(segment),
    .bcd_digits(bcd_digits),
    .bad_pattern(bad_pattern),
    .frame_valid(frame_valid),
    .sample_strobe(sample_strobe),
    .sample_digit(sample_digit),
    .sample_bcd(sample_bcd),
    .anode_err(anode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sample_strobe) begin
      strobe_cnt++;
      last_digit = sample_digit;
      last_bcd   = sample_bcd;
    end
    if (frame_valid) begin
      fv_cnt++;
      fv_digit = sample_digit;
      if (!sample_strobe) fv_lone++;
    end
    if (anode_err) err_cnt++;
  endtask

  task automatic blank(input int n);
    anode   = 4'hF;
    segment = 7'h00;
    repeat (n) tick();
  endtask

  // Show digit d for 20 cycles, then a 2-cycle blank.
  task automatic scan(input logic [1:0] d, input logic [6:0] seg);
    anode   = ~(4'b0001 << d);
    segment = seg;
    repeat (20) tick();
    blank(2);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    anode   = 4'hF;
    segment = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bcd_digits, bad_pattern, frame_valid, sample_strobe, sample_digit, sample_bcd, anode_err} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {bcd_digits, bad_pattern, frame_valid, sample_strobe, sample_digit, sample_bcd, anode_err});
    end
    rst_n = 1'b1;
    blank(50);
    checks++;
    if (strobe_cnt + fv_cnt + err_cnt !== 0) begin
      errors++;
      $display("FAIL idle_pulses: strobes %0d frames %0d errs %0d required 0", strobe_cnt, fv_cnt, err_cnt);
    end
    checks++;
    if ({bcd_digits, bad_pattern, sample_digit, sample_bcd} !== 26'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h required 0", {bcd_digits, bad_pattern, sample_digit, sample_bcd});
    end
  endtask

  task automatic test_latency();
    int s0;
    int first;
    s0      = strobe_cnt;
    first   = 0;
    anode   = 4'b1110;
    segment = 7'h5B;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (sample_strobe && first == 0) first = n;
    end
    checks++;
    if (first !== 8) begin
      errors++;
      $display("FAIL latency: strobe at edge %0d required 8", first);
    end
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL single_capture: got %0d strobes required 1", strobe_cnt - s0);
    end
    checks++;
    if ({last_digit, last_bcd} !== {2'd0, 4'd2}) begin
      errors++;
      $display("FAIL latency_data: digit %0d bcd %h required digit 0 bcd 2", last_digit, last_bcd);
    end
    blank(2);
  endtask

  task automatic test_frame();
    int s0, f0;
    s0 = strobe_cnt;
    f0 = fv_cnt;
    scan(2'd0, 7'h06);
    scan(2'd1, 7'h4F);
    scan(2'd2, 7'h66);
    checks++;
    if (fv_cnt !== f0) begin
      errors++;
      $display("FAIL early_frame: got %0d frames required %0d", fv_cnt, f0);
    end
    scan(2'd3, 7'h7F);
    checks++;
    if (strobe_cnt - s0 !== 4 || fv_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL frame_counts: strobes %0d frames %0d required 4 and 1", strobe_cnt - s0, fv_cnt - f0);
    end
    checks++;
    if (fv_lone !== 0 || fv_digit !== 2'd3) begin
      errors++;
      $display("FAIL frame_align: lone %0d digit %0d required 0 and 3", fv_lone, fv_digit);
    end
    checks++;
    if ({bcd_digits, bad_pattern} !== {16'h8431, 4'b0000}) begin
      errors++;
      $display("FAIL frame_data: got %h/%b required 8431/0000", bcd_digits, bad_pattern);
    end
  endtask

  task automatic test_bad_pattern();
    scan(2'd0, 7'h3F);
    scan(2'd1, 7'h06);
    scan(2'd2, 7'h77);
    checks++;
    if ({last_digit, last_bcd} !== {2'd2, 4'hF}) begin
      errors++;
      $display("FAIL bad_sample: digit %0d bcd %h required digit 2 bcd F", last_digit, last_bcd);
    end
    scan(2'd3, 7'h4F);
    checks++;
    if ({bcd_digits, bad_pattern} !== {16'h3F10, 4'b0100}) begin
      errors++;
      $display("FAIL bad_frame: got %h/%b required 3F10/0100", bcd_digits, bad_pattern);
    end
    scan(2'd0, 7'h6D);
    scan(2'd1, 7'h7D);
    scan(2'd2, 7'h07);
    scan(2'd3, 7'h6F);
    checks++;
    if ({bcd_digits, bad_pattern} !== {16'h9765, 4'b0000}) begin
      errors++;
      $display("FAIL clean_frame: got %h/%b required 9765/0000", bcd_digits, bad_pattern);
    end
  endtask

  task automatic test_overwrite();
    scan(2'd0, 7'h06);
    scan(2'd0, 7'h7D);
    scan(2'd1, 7'h3F);
    scan(2'd2, 7'h3F);
    scan(2'd3, 7'h3F);
    checks++;
    if (bcd_digits !== 16'h0006) begin
      errors++;
      $display("FAIL overwrite: got %h required 0006", bcd_digits);
    end
  endtask

  task automatic test_glitch_and_anode_err();
    int s0, e0, f0;
    s0 = strobe_cnt;
    e0 = err_cnt;
    f0 = fv_cnt;
    anode   = 4'b1101;
    segment = 7'h06;
    repeat (3) tick();
    blank(20);
    checks++;
    if (strobe_cnt !== s0) begin
      errors++;
      $display("FAIL glitch: got %0d strobes required 0", strobe_cnt - s0);
    end
    anode   = 4'b1100;
    segment = 7'h06;
    repeat (20) tick();
    blank(2);
    checks++;
    if (err_cnt - e0 !== 1 || strobe_cnt !== s0) begin
      errors++;
      $display("FAIL anode_err: errs %0d strobes %0d required 1 and 0", err_cnt - e0, strobe_cnt - s0);
    end
    // A multi-low anode must not mark any digit as seen.
    scan(2'd0, 7'h4F);
    scan(2'd1, 7'h4F);
    scan(2'd2, 7'h4F);
    checks++;
    if (fv_cnt !== f0) begin
      errors++;
      $display("FAIL err_seen: got %0d frames required 0", fv_cnt - f0);
    end
    scan(2'd3, 7'h4F);
    checks++;
    if (fv_cnt - f0 !== 1 || bcd_digits !== 16'h3333) begin
      errors++;
      $display("FAIL err_frame: frames %0d data %h required 1 and 3333", fv_cnt - f0, bcd_digits);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    scan(2'd0, 7'h5B);
    scan(2'd1, 7'h66);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bcd_digits, bad_pattern, sample_strobe, frame_valid} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h required 0", {bcd_digits, bad_pattern, sample_strobe, frame_valid});
    end
    f0 = fv_cnt;
    scan(2'd2, 7'h7F);
    scan(2'd3, 7'h07);
    checks++;
    if (fv_cnt !== f0 || bcd_digits !== 16'h0000) begin
      errors++;
      $display("FAIL partial_discard: frames %0d data %h required 0 and 0000", fv_cnt - f0, bcd_digits);
    end
    scan(2'd0, 7'h3F);
    scan(2'd1, 7'h6F);
    checks++;
    if (fv_cnt - f0 !== 1 || bcd_digits !== 16'h7890) begin
      errors++;
      $display("FAIL post_reset_frame: frames %0d data %h required 1 and 7890", fv_cnt - f0, bcd_digits);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    anode   = 4'hF;
    segment = 7'h00;
    test_reset();
    test_latency();
    test_frame();
    test_bad_pattern();
    test_overwrite();
    test_glitch_and_anode_err();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
